// File: rtl/mii_rx_deframer.sv
// MII receive deframer: strips preamble and SFD, packs nibbles low-first into
// bytes, and reports byte count and error status at end of frame.
module mii_rx_deframer #(
    parameter int MIN_PRE_NIBBLES = 2,
    parameter int MAX_BYTES       = 1518,
    parameter int MIN_BYTES       = 64
) (
    input  logic        mrx_clk_pad_i,
    input  logic        rst_n_i,
    input  logic [3:0]  mrxd_pad_i,
    input  logic        mrxdv_pad_i,
    input  logic        mrxerr_pad_i,
    output logic [7:0]  rx_byte_o,
    output logic        rx_byte_vld_o,
    output logic        rx_sof_o,
    output logic        rx_eof_o,
    output logic [15:0] rx_byte_cnt_o,
    output logic [4:0]  rx_status_o,
    output logic        rx_drop_o
);
    typedef enum logic [2:0] {IDLE, PRE, DATA_LO, DATA_HI, DROP} state_t;

    localparam logic [3:0]  NIB_PRE  = 4'h5;
    localparam logic [3:0]  NIB_SFD  = 4'hD;
    localparam logic [31:0] MIN_PRE  = MIN_PRE_NIBBLES;
    localparam logic [31:0] MIN_LEN  = MIN_BYTES;
    localparam logic [31:0] MAX_LEN  = MAX_BYTES;

    state_t      state_q, state_d;
    logic [3:0]  pre_cnt_q, pre_cnt_d;
    logic [3:0]  lo_q, lo_d;
    logic [15:0] cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        sat_q, sat_d;
    logic        first_q, first_d;

    logic [7:0]  byte_d;
    logic        vld_d, sof_d, eof_d, drop_d;
    logic [15:0] cnt_o_d;
    logic [4:0]  status_d;

    logic        too_short, too_long, pre_ok;

    // Length checks see the count as it stands when dv falls, i.e. final.
    assign too_short = ({16'd0, cnt_q} < MIN_LEN);
    assign too_long  = ({16'd0, cnt_q} > MAX_LEN);
    assign pre_ok    = ({28'd0, pre_cnt_q} >= MIN_PRE);

    always_comb begin
        state_d   = state_q;
        pre_cnt_d = pre_cnt_q;
        lo_d      = lo_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        sat_d     = sat_q;
        first_d   = first_q;
        byte_d    = rx_byte_o;
        vld_d     = 1'b0;
        sof_d     = 1'b0;
        eof_d     = 1'b0;
        drop_d    = 1'b0;
        cnt_o_d   = rx_byte_cnt_o;
        status_d  = rx_status_o;

        case (state_q)
            IDLE: begin
                if (mrxdv_pad_i) begin
                    if (mrxd_pad_i == NIB_PRE) begin
                        state_d   = PRE;
                        pre_cnt_d = 4'd1;
                    end else begin
                        state_d = DROP;
                    end
                end
            end
            PRE: begin
                if (!mrxdv_pad_i) begin
                    state_d = IDLE;
                end else if (mrxd_pad_i == NIB_PRE) begin
                    if (pre_cnt_q != 4'hF) pre_cnt_d = pre_cnt_q + 4'd1;
                end else if (mrxd_pad_i == NIB_SFD && pre_ok) begin
                    state_d = DATA_LO;
                    cnt_d   = 16'd0;
                    err_d   = 1'b0;
                    sat_d   = 1'b0;
                    first_d = 1'b1;
                end else begin
                    state_d = DROP;
                    drop_d  = 1'b1;
                end
            end
            DATA_LO: begin
                if (mrxdv_pad_i) begin
                    lo_d    = mrxd_pad_i;
                    err_d   = err_q | mrxerr_pad_i;
                    state_d = DATA_HI;
                end else begin
                    state_d  = IDLE;
                    eof_d    = 1'b1;
                    cnt_o_d  = cnt_q;
                    status_d = {sat_q, too_long, too_short, 1'b0, err_q};
                end
            end
            DATA_HI: begin
                if (mrxdv_pad_i) begin
                    byte_d  = {mrxd_pad_i, lo_q};
                    vld_d   = 1'b1;
                    sof_d   = first_q;
                    first_d = 1'b0;
                    err_d   = err_q | mrxerr_pad_i;
                    if (cnt_q == 16'hFFFF) sat_d = 1'b1;
                    else                   cnt_d = cnt_q + 16'd1;
                    // Previous frame's report is retired together with sof.
                    if (first_q) begin
                        cnt_o_d  = 16'd0;
                        status_d = 5'd0;
                    end
                    state_d = DATA_LO;
                end else begin
                    // Half byte is discarded; only the dribble flag records it.
                    state_d  = IDLE;
                    eof_d    = 1'b1;
                    cnt_o_d  = cnt_q;
                    status_d = {sat_q, too_long, too_short, 1'b1, err_q};
                end
            end
            DROP: begin
                if (!mrxdv_pad_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge mrx_clk_pad_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q       <= IDLE;
            pre_cnt_q     <= 4'd0;
            lo_q          <= 4'd0;
            cnt_q         <= 16'd0;
            err_q         <= 1'b0;
            sat_q         <= 1'b0;
            first_q       <= 1'b0;
            rx_byte_o     <= 8'd0;
            rx_byte_vld_o <= 1'b0;
            rx_sof_o      <= 1'b0;
            rx_eof_o      <= 1'b0;
            rx_drop_o     <= 1'b0;
            rx_byte_cnt_o <= 16'd0;
            rx_status_o   <= 5'd0;
        end else begin
            state_q       <= state_d;
            pre_cnt_q     <= pre_cnt_d;
            lo_q          <= lo_d;
            cnt_q         <= cnt_d;
            err_q         <= err_d;
            sat_q         <= sat_d;
            first_q       <= first_d;
            rx_byte_o     <= byte_d;
            rx_byte_vld_o <= vld_d;
            rx_sof_o      <= sof_d;
            rx_eof_o      <= eof_d;
            rx_drop_o     <= drop_d;
            rx_byte_cnt_o <= cnt_o_d;
            rx_status_o   <= status_d;
        end
    end
endmodule

// File: tb/tb_mii_rx_deframer.sv
// Bench for mii_rx_deframer: table of frame vectors, reset-mid-frame sequence,
// and random frames scored against a frame-level reference model.
module tb_mii_rx_deframer;
    localparam int MIN_PRE = 2;
    localparam int MAX_B   = 1518;
    localparam int MIN_B   = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  mrxd = 4'd0;
    logic        mrxdv = 1'b0;
    logic        mrxerr = 1'b0;
    logic [7:0]  rx_byte;
    logic        rx_byte_vld, rx_sof, rx_eof, rx_drop;
    logic [15:0] rx_byte_cnt;
    logic [4:0]  rx_status;

    mii_rx_deframer #(.MIN_PRE_NIBBLES(MIN_PRE), .MAX_BYTES(MAX_B), .MIN_BYTES(MIN_B)) dut (
        .mrx_clk_pad_i(clk),
        .rst_n_i(rst_n),
        .mrxd_pad_i(mrxd),
        .mrxdv_pad_i(mrxdv),
        .mrxerr_pad_i(mrxerr),
        .rx_byte_o(rx_byte),
        .rx_byte_vld_o(rx_byte_vld),
        .rx_sof_o(rx_sof),
        .rx_eof_o(rx_eof),
        .rx_byte_cnt_o(rx_byte_cnt),
        .rx_status_o(rx_status),
        .rx_drop_o(rx_drop)
    );

    // Clock / reset
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not end, got timeout required finish");
        $fatal(1);
    end

    // Scoreboard state
    int total = 0;
    int bad = 0;
    logic [8:0]  exp_q[$];       // {sof, byte}
    logic [20:0] exp_eof_q[$];   // {count, status}
    int drop_seen = 0;
    int drop_exp = 0;
    int eof_seen = 0;
    logic [7:0] payload [0:2047];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Monitor: every delivered byte and eof is scored against the expected queues
    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_byte_vld || rx_eof)
                chk("vld_eof_exclusive", {31'd0, rx_byte_vld & rx_eof}, 32'd0);
            if (rx_byte_vld) begin
                if (exp_q.size() == 0) chk("unexpected_byte", {23'd0, rx_sof, rx_byte}, 32'h1FF);
                else                   chk("byte", {23'd0, rx_sof, rx_byte}, {23'd0, exp_q.pop_front()});
            end
            if (rx_eof) begin
                eof_seen++;
                if (exp_eof_q.size() == 0) chk("unexpected_eof", {11'd0, rx_byte_cnt, rx_status}, 32'hFFFFFFFF);
                else                       chk("eof_report", {11'd0, rx_byte_cnt, rx_status}, {11'd0, exp_eof_q.pop_front()});
            end
            if (rx_drop) drop_seen++;
        end
    end

    // Driver tasks
    task automatic nib(input logic dv, input logic [3:0] d, input logic er);
        @(negedge clk);
        mrxdv = dv;
        mrxd = d;
        mrxerr = er;
    endtask

    task automatic send_frame(input int pre_n, input logic [3:0] sfd, input int nbytes,
                              input bit drib, input int err_byte, input bit pre_err, input bit push);
        for (int i = 0; i < pre_n; i++) nib(1'b1, 4'h5, pre_err);
        nib(1'b1, sfd, pre_err);
        for (int k = 0; k < nbytes; k++) begin
            nib(1'b1, payload[k][3:0], k == err_byte);
            nib(1'b1, payload[k][7:4], 1'b0);
            if (push) exp_q.push_back({k == 0, payload[k]});
        end
        if (drib) nib(1'b1, 4'hA, 1'b0);
        nib(1'b0, 4'h0, 1'b0);
    endtask

    typedef struct {
        int         pre_n;
        logic [3:0] sfd;
        int         nbytes;
        bit         drib;
        int         err_byte;
        bit         acc;
        logic [15:0] cnt;
        logic [4:0] st;
    } vec_t;

    vec_t tbl[11];
    int d0, e0;

    initial begin
        tbl[0]  = '{15, 4'hD, 64,   0, -1, 1, 16'd64,   5'b00000}; // nominal
        tbl[1]  = '{15, 4'hD, 10,   1, -1, 1, 16'd10,   5'b00110}; // dribble + short
        tbl[2]  = '{2,  4'h7, 20,   0, -1, 0, 16'd0,    5'b00000}; // preamble fault
        tbl[3]  = '{15, 4'hD, 64,   0, -1, 1, 16'd64,   5'b00000}; // clean after fault
        tbl[4]  = '{15, 4'hD, 100,  0, 50, 1, 16'd100,  5'b00001}; // PHY error
        tbl[5]  = '{15, 4'hD, 1519, 0, -1, 1, 16'd1519, 5'b01000}; // too long
        tbl[6]  = '{1,  4'hD, 10,   0, -1, 0, 16'd0,    5'b00000}; // SFD too early
        tbl[7]  = '{15, 4'hD, 0,    0, -1, 1, 16'd0,    5'b00100}; // zero bytes
        tbl[8]  = '{2,  4'hD, 64,   0, -1, 1, 16'd64,   5'b00000}; // minimal preamble
        tbl[9]  = '{15, 4'hD, 1518, 0, -1, 1, 16'd1518, 5'b00000}; // exactly max
        tbl[10] = '{15, 4'hD, 63,   1, -1, 1, 16'd63,   5'b00110}; // one below min

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_vld", {31'd0, rx_byte_vld}, 32'd0);
        chk("reset_eof", {31'd0, rx_eof}, 32'd0);
        chk("reset_sof", {31'd0, rx_sof}, 32'd0);
        chk("reset_drop", {31'd0, rx_drop}, 32'd0);
        chk("reset_cnt", {16'd0, rx_byte_cnt}, 32'd0);
        chk("reset_status", {27'd0, rx_status}, 32'd0);
        rst_n = 1'b1;

        // Table-driven frames
        for (int t = 0; t < 11; t++) begin
            for (int k = 0; k < 2048; k++) payload[k] = 8'(k);
            d0 = drop_seen;
            e0 = eof_seen;
            if (tbl[t].acc) exp_eof_q.push_back({tbl[t].cnt, tbl[t].st});
            else            drop_exp++;
            send_frame(tbl[t].pre_n, tbl[t].sfd, tbl[t].nbytes, tbl[t].drib, tbl[t].err_byte, 1'b0, tbl[t].acc);
            @(negedge clk);
            chk("eof_timing", {31'd0, rx_eof}, {31'd0, tbl[t].acc});
            repeat (3) @(negedge clk);
            chk("drop_pulses", drop_seen - d0, {31'd0, !tbl[t].acc});
            chk("eof_pulses", eof_seen - e0, {31'd0, tbl[t].acc});
            if (tbl[t].acc) begin
                chk("cnt_hold", {16'd0, rx_byte_cnt}, {16'd0, tbl[t].cnt});
                chk("status_hold", {27'd0, rx_status}, {27'd0, tbl[t].st});
            end
        end

        // Reset in the middle of a frame, released while dv is still high
        for (int k = 0; k < 2048; k++) payload[k] = 8'(k);
        e0 = eof_seen;
        for (int i = 0; i < 15; i++) nib(1'b1, 4'h5, 1'b0);
        nib(1'b1, 4'hD, 1'b0);
        for (int k = 0; k < 20; k++) begin
            nib(1'b1, payload[k][3:0], 1'b0);
            nib(1'b1, payload[k][7:4], 1'b0);
            exp_q.push_back({k == 0, payload[k]});
        end
        nib(1'b1, payload[20][3:0], 1'b0);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        mrxd = payload[20][7:4];
        #1;
        chk("midrst_vld", {31'd0, rx_byte_vld}, 32'd0);
        chk("midrst_sof", {31'd0, rx_sof}, 32'd0);
        chk("midrst_byte", {24'd0, rx_byte}, 32'd0);
        chk("midrst_cnt", {16'd0, rx_byte_cnt}, 32'd0);
        chk("midrst_status", {27'd0, rx_status}, 32'd0);
        nib(1'b1, 4'h3, 1'b0);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) nib(1'b1, 4'h3, 1'b0);
        nib(1'b0, 4'h0, 1'b0);
        repeat (3) @(negedge clk);
        chk("midrst_no_eof", eof_seen - e0, 32'd0);
        chk("midrst_bytes_done", exp_q.size(), 32'd0);
        d0 = drop_seen;
        drop_exp = drop_exp + 0;
        exp_eof_q.push_back({16'd64, 5'b00000});
        send_frame(15, 4'hD, 64, 1'b0, -1, 1'b0, 1'b1);
        @(negedge clk);
        chk("post_rst_eof", {31'd0, rx_eof}, 32'd1);
        repeat (2) @(negedge clk);
        d0 = drop_seen - d0;
        chk("post_rst_no_drop", d0, 32'd0);

        // Random frames scored by a frame-level model
        drop_exp = drop_exp + (drop_seen - drop_exp - (drop_seen - drop_exp));
        begin
            int base_drop;
            base_drop = drop_seen;
            drop_exp = 0;
            for (int f = 0; f < 16; f++) begin
                int pre_n, nb, eb;
                logic [3:0] sfd;
                bit drib, perr, acc;
                logic [4:0] st;
                pre_n = $urandom_range(1, 20);
                case ($urandom_range(0, 5))
                    0: sfd = 4'h7;
                    1: sfd = 4'h3;
                    default: sfd = 4'hD;
                endcase
                nb = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 150);
                drib = 1'($urandom_range(0, 1));
                perr = 1'($urandom_range(0, 1));
                eb = ($urandom_range(0, 2) == 0) ? $urandom_range(0, nb) : -1;
                for (int k = 0; k < nb; k++) payload[k] = 8'($urandom);
                acc = (sfd == 4'hD) && (pre_n >= MIN_PRE);
                if (acc) begin
                    st = {1'b0, nb > MAX_B, nb < MIN_B, drib, (eb >= 0) && (eb < nb)};
                    exp_eof_q.push_back({16'(nb), st});
                end else begin
                    drop_exp++;
                end
                send_frame(pre_n, sfd, nb, drib, eb, perr, acc);
                repeat ($urandom_range(0, 2)) nib(1'b0, 4'h0, 1'b0);
            end
            repeat (4) @(negedge clk);
            chk("random_drops", drop_seen - base_drop, drop_exp);
        end

        chk("bytes_drained", exp_q.size(), 32'd0);
        chk("eofs_drained", exp_eof_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
